cdc_handshake_tx: RTL and testbench

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

---
 rtl/cdc_handshake_tx.sv | 105 ++++++++++
 tb/tb_cdc_handshake_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - four-phase req/ack sender with ack synchronizer; optional timeout abort under CDC_TX_TIMEOUT_EN
module cdc_handshake_tx #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             ack,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_HI = 2'd1;
  localparam logic [1:0] REQ_LO = 2'd2;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cdc_handshake_tx: SYNC_STAGES and TIMEOUT_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic                   accept;
  logic                   complete;
  logic                   tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign in_ready = (state == IDLE) && !ack_s;
  assign accept   = in_valid && in_ready;
  assign complete = (state == REQ_LO) && !ack_s;

  // A real handshake edge always wins over a timeout hitting in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ_HI;
      REQ_HI:  if (ack_s) state_nxt = REQ_LO;
               else if (tmo_hit) state_nxt = IDLE;
      REQ_LO:  if (!ack_s) state_nxt = IDLE;
               else if (tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req     <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == REQ_HI);
      done  <= complete;
      if (accept) begin
        tx_data <= in_data;
      end
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             abort;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign abort   = (state != IDLE) && (state_nxt == IDLE) && !complete;

  // Counter restarts on every state change, so it measures time spent in one phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= abort;
      if (state_nxt != state || state_nxt == IDLE) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - directed and randomized checks of cdc_handshake_tx against a timing/ordering model
module tb_cdc_handshake_tx;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             req;
  logic [WIDTH-1:0] tx_data;
  logic             ack;
  logic             done;
  logic             err;

  cdc_handshake_tx #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .req(req),
    .tx_data(tx_data),
    .ack(ack),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;
  int cyc;
  int dly;
  logic [7:0] hist;
  logic resp_en;
  logic resp_ack;
  logic ack_man;
  logic prev_req;
  logic [WIDTH-1:0] prev_tx;
  int done_cnt;
  int err_cnt;
  int both_bad;
  int stab_bad;
  int done_cyc_q[$];
  int acc_cyc_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] exp_q[$];

  // Remote side: ack mirrors req with a programmable delay, or is driven by hand.
  assign ack = resp_en ? resp_ack : ack_man;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    hist = {hist[6:0], req};
    resp_ack = hist[dly];
    if (req && prev_req && tx_data !== prev_tx) stab_bad++;
    if (req && !prev_req) got_q.push_back(tx_data);
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
    if (err) err_cnt++;
    if (done && err) both_bad++;
    prev_req = req;
    prev_tx  = tx_data;
  endtask

  task automatic clear_book();
    done_cnt = 0;
    err_cnt  = 0;
    both_bad = 0;
    stab_bad = 0;
    done_cyc_q.delete();
    acc_cyc_q.delete();
    got_q.delete();
    exp_q.delete();
    prev_req = 1'b0;
    prev_tx  = '0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    hist     = '0;
    resp_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    clear_book();
  endtask

  initial begin
    int acc;
    int fall;
    int gap;
    int flag;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    dly      = 0;
    hist     = '0;
    resp_en  = 1'b0;
    resp_ack = 1'b0;
    ack_man  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear_book();

    // Basic transfer with an immediate echo.
    resp_en = 1'b1;
    dly = 0;
    do_reset();
    step();
    check("rst_req", req, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    acc = cyc;
    step();
    in_valid = 1'b0;
    check("t1_req_rise", req, 1);
    check("t1_tx_data", tx_data, 8'hA5);
    fall = -1;
    for (int i = 0; i < 30 && done_cnt == 0; i++) begin
      step();
      if (!req && fall < 0) fall = cyc;
    end
    check("t1_done_seen", done_cnt, 1);
    check("t1_req_fall_cycle", fall - acc, SYNC + 2);
    check("t1_done_cycle", cyc - acc, 2 * SYNC + 3);
    check("t1_in_ready_back", in_ready, 1);
    step();
    check("t1_done_one_cycle", done, 0);
    repeat (10) step();
    check("t1_single_done", done_cnt, 1);

    // Back-to-back transfers with in_valid held high.
    do_reset();
    step();
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_data = 8'h02;
    for (int i = 0; i < 40 && done_cnt < 2; i++) step();
    in_valid = 1'b0;
    check("t2_two_dones", done_cnt, 2);
    gap = (done_cyc_q.size() == 2) ? done_cyc_q[1] - done_cyc_q[0] : -1;
    check("t2_done_gap", gap, 2 * SYNC + 3);
    check("t2_rises", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_data0", got_q[0], 8'h01);
      check("t2_data1", got_q[1], 8'h02);
    end
    check("t2_tx_stable", stab_bad, 0);

    // Stale ack present at reset release.
    resp_en = 1'b0;
    ack_man = 1'b1;
    do_reset();
    step();
    step();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      check("t3_blocked_ready", in_ready, 0);
      check("t3_blocked_req", req, 0);
      step();
    end
    ack_man = 1'b0;
    for (int i = 0; i < SYNC; i++) begin
      check("t3_ready_wait", in_ready, 0);
      step();
    end
    check("t3_ready_after_fall", in_ready, 1);
    check("t3_req_before_accept", req, 0);
    step();
    in_valid = 1'b0;
    check("t3_req_rise", req, 1);
    check("t3_tx_data", tx_data, 8'h3C);
    resp_en = 1'b1;
    for (int i = 0; i < 30 && done_cnt == 0; i++) step();
    check("t3_done", done_cnt, 1);

    // Reset pulse in the middle of REQ_HI.
    resp_en = 1'b0;
    ack_man = 1'b0;
    do_reset();
    step();
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    check("t4_req_hi", req, 1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t4_req_cleared", req, 0);
    check("t4_tx_cleared", tx_data, 0);
    check("t4_done_cleared", done, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("t4_no_done", done_cnt, 0);
    check("t4_req_idle", req, 0);

`ifdef CDC_TX_TIMEOUT_EN
    // Timeout abort with ack stuck low.
    do_reset();
    step();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (req) acc++;
      step();
    end
    check("t5_req_high_cycles", acc, TMO);
    check("t5_req_dropped", req, 0);
    check("t5_err_pulses", err_cnt, 1);
    check("t5_no_done", done_cnt, 0);
    check("t5_in_ready", in_ready, 1);
`else
    // Without the timeout the request waits forever.
    do_reset();
    step();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    flag = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!req || err) flag++;
      step();
    end
    check("t5_req_held", flag, 0);
    check("t5_req_still_high", req, 1);
    check("t5_no_err", err_cnt, 0);
`endif

    // Randomized payloads, gaps and echo delay against the ordering/latency model.
    resp_en = 1'b1;
    ack_man = 1'b0;
    dly = int'($urandom_range(0, 3));
    do_reset();
    step();
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(WIDTH'($urandom));
      in_valid = 1'b1;
      in_data  = exp_q[k];
      for (int t = 0; t < 100 && !in_ready; t++) step();
      acc_cyc_q.push_back(cyc);
      step();
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      gap = int'($urandom_range(0, 3));
      repeat (gap) step();
    end
    for (int i = 0; i < 100 && done_cnt < 20; i++) step();
    check("rnd_done_count", done_cnt, 20);
    check("rnd_rise_count", got_q.size(), 20);
    for (int k = 0; k < 20; k++) begin
      if (k < got_q.size()) check("rnd_data", got_q[k], exp_q[k]);
      if (k < done_cyc_q.size())
        check("rnd_latency", done_cyc_q[k] - acc_cyc_q[k], 2 * SYNC + 3 + 2 * dly);
    end
    check("rnd_tx_stable", stab_bad, 0);
    check("rnd_no_err", err_cnt, 0);
    check("rnd_done_err_exclusive", both_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
